// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: word width, FSM encodings,
// port IDs and the alignment/range fault check.
package dmem_arbiter_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Byte address must be 8-byte aligned and its word index inside the memory.
  function automatic logic addr_fault(input logic [WORD-1:0] addr,
                                      input int unsigned     size);
    logic [WORD-1:0] size_w;
    size_w = WORD'(size);
    return (addr[2:0] != 3'b000) || ((addr >> 3) >= size_w);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer names the port that wins a tie and
// moves to the other port whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      rr_ptr <= grant[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU (port 0) and the
// debug/loader (port 1), one transaction at a time, with fault filtering.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request; grant is combinational, handshake here
// ST_ISSUE | drive mem_read/mem_write for one cycle, memory samples at end
// ST_RESP  | one-cycle response pulse with load data (0 for stores)
// ST_ERR   | one-cycle error response, memory never touched
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int SIZE     = 1024,
  parameter int CHECK_EN = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p0_req_valid,
  input  logic            p0_req_write,
  input  logic [WORD-1:0] p0_req_addr,
  input  logic [WORD-1:0] p0_req_wdata,
  output logic            p0_req_ready,
  input  logic            p1_req_valid,
  input  logic            p1_req_write,
  input  logic [WORD-1:0] p1_req_addr,
  input  logic [WORD-1:0] p1_req_wdata,
  output logic            p1_req_ready,
  output logic            resp_valid,
  output logic            resp_port,
  output logic [WORD-1:0] resp_data,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_address,
  output logic [WORD-1:0] mem_write_data,
  input  logic [WORD-1:0] mem_read_data
);

  state_e          state, state_nxt;
  logic [1:0]      grant;
  logic            advance;
  logic            sel_port;
  logic            sel_write;
  logic [WORD-1:0] sel_addr;
  logic [WORD-1:0] sel_wdata;
  logic            sel_fault;

  logic            cmd_write;
  logic            cmd_port;
  logic [WORD-1:0] cmd_addr;
  logic [WORD-1:0] cmd_wdata;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({p1_req_valid, p0_req_valid}),
    .advance (advance),
    .grant   (grant)
  );

  // Ready is gated by reset_n so it reads 0 while reset is held even if a
  // requester keeps valid high.
  assign advance      = reset_n && (state == ST_IDLE) && (grant != 2'b00);
  assign p0_req_ready = advance && grant[0];
  assign p1_req_ready = advance && grant[1];

  assign sel_port  = grant[1] ? PORT1 : PORT0;
  assign sel_write = grant[1] ? p1_req_write : p0_req_write;
  assign sel_addr  = grant[1] ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant[1] ? p1_req_wdata : p0_req_wdata;
  assign sel_fault = (CHECK_EN != 0) && addr_fault(sel_addr, SIZE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_write <= 1'b0;
      cmd_port  <= PORT0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        cmd_write <= sel_write;
        cmd_port  <= sel_port;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    resp_valid     = 1'b0;
    resp_port      = 1'b0;
    resp_data      = '0;
    resp_err       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state)
      ST_IDLE: begin
        if (advance) state_nxt = sel_fault ? ST_ERR : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_read       = ~cmd_write;
        mem_write      = cmd_write;
        mem_address    = cmd_addr;
        mem_write_data = cmd_wdata;
        state_nxt      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_port  = cmd_port;
        resp_data  = cmd_write ? '0 : mem_read_data;
        state_nxt  = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_port  = cmd_port;
        resp_err   = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: checked and unchecked instances, each
// backed by a simple registered-read memory model.
module tb_dmem_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         p0_req_valid = 0, p0_req_write = 0;
  logic [W-1:0] p0_req_addr = '0, p0_req_wdata = '0;
  logic         p1_req_valid = 0, p1_req_write = 0;
  logic [W-1:0] p1_req_addr = '0, p1_req_wdata = '0;
  logic         p0_req_ready, p1_req_ready;
  logic         resp_valid, resp_port, resp_err;
  logic [W-1:0] resp_data;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_address, mem_write_data, mem_read_data;

  logic         nc_p0_req_valid = 0;
  logic [W-1:0] nc_p0_req_addr = '0;
  logic         nc_p0_req_ready, nc_p1_req_ready;
  logic         nc_resp_valid, nc_resp_port, nc_resp_err;
  logic [W-1:0] nc_resp_data;
  logic         nc_mem_read, nc_mem_write;
  logic [W-1:0] nc_mem_address, nc_mem_write_data, nc_mem_read_data;

  logic         bd_we = 0;
  logic [9:0]   bd_idx = '0;
  logic [W-1:0] bd_data = '0;
  logic [W-1:0] mem  [0:1023];
  logic [W-1:0] mem2 [0:1023];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.SIZE(1024), .CHECK_EN(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready),
    .p1_req_valid(p1_req_valid), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready),
    .resp_valid(resp_valid), .resp_port(resp_port), .resp_data(resp_data), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.SIZE(1024), .CHECK_EN(0)) u_nc (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(nc_p0_req_valid), .p0_req_write(1'b0),
    .p0_req_addr(nc_p0_req_addr), .p0_req_wdata('0), .p0_req_ready(nc_p0_req_ready),
    .p1_req_valid(1'b0), .p1_req_write(1'b0),
    .p1_req_addr('0), .p1_req_wdata('0), .p1_req_ready(nc_p1_req_ready),
    .resp_valid(nc_resp_valid), .resp_port(nc_resp_port), .resp_data(nc_resp_data), .resp_err(nc_resp_err),
    .mem_read(nc_mem_read), .mem_write(nc_mem_write), .mem_address(nc_mem_address),
    .mem_write_data(nc_mem_write_data), .mem_read_data(nc_mem_read_data)
  );

  // Memory models: word index is byte address >> 3; backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx]  <= bd_data;
      mem2[bd_idx] <= bd_data;
    end
    if (mem_write) mem[mem_address[12:3]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[12:3]];
    if (nc_mem_write) mem2[nc_mem_address[12:3]] <= nc_mem_write_data;
    if (nc_mem_read)  nc_mem_read_data <= mem2[nc_mem_address[12:3]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [W-1:0] data);
    bd_we = 1; bd_idx = idx; bd_data = data;
    tick();
    bd_we = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    p0_req_valid = 1; p1_req_valid = 1;
    tick();
    tests++;
    if ({p0_req_ready, p1_req_ready, resp_valid, resp_err, mem_read, mem_write} !== 6'b0 ||
        resp_data !== '0 || mem_address !== '0 || mem_write_data !== '0) begin
      failed++;
      $display("FAIL reset_outputs: rdy=%b%b rv=%b err=%b mr=%b mw=%b required all 0",
               p0_req_ready, p1_req_ready, resp_valid, resp_err, mem_read, mem_write);
    end
    p0_req_valid = 0; p1_req_valid = 0;
    for (int i = 0; i < 1024; i++) preload(i[9:0], '0);
    preload(10'd4, 32'h0000_4444);
    preload(10'd5, 32'h0000_5555);
    preload(10'd1023, 32'hCAFE_F00D);
    preload(10'd2, 32'h1234_5678);
    reset_n = 1;
    tick();
  endtask

  task automatic test_store_load();
    p0_req_valid = 1; p0_req_write = 1; p0_req_addr = 32'h10; p0_req_wdata = 32'hDEAD;
    #1;
    tests++;
    if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
      failed++; $display("FAIL store_ready: got %b%b required p0=1 p1=0", p0_req_ready, p1_req_ready);
    end
    tick();
    p0_req_valid = 0;
    tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h10 || mem_write_data !== 32'hDEAD) begin
      failed++; $display("FAIL store_issue: mw=%b mr=%b addr=%h wd=%h required 1 0 10 dead",
                         mem_write, mem_read, mem_address, mem_write_data);
    end
    tick();
    tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_port !== 1'b0 || resp_data !== '0 || mem_write !== 1'b0) begin
      failed++; $display("FAIL store_resp: rv=%b err=%b port=%b data=%h mw=%b required 1 0 0 0 0",
                         resp_valid, resp_err, resp_port, resp_data, mem_write);
    end
    tick();
    p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 32'h10;
    tick();
    p0_req_valid = 0;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 32'h10 || resp_valid !== 1'b0) begin
      failed++; $display("FAIL load_issue: mr=%b addr=%h rv=%b required 1 10 0", mem_read, mem_address, resp_valid);
    end
    tick();
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD || resp_err !== 1'b0) begin
      failed++; $display("FAIL load_resp: rv=%b data=%h err=%b required 1 dead 0", resp_valid, resp_data, resp_err);
    end
    tick();
    tests++;
    if (resp_valid !== 1'b0) begin
      failed++; $display("FAIL load_pulse: rv=%b required 0", resp_valid);
    end
  endtask

  task automatic test_misaligned();
    p1_req_valid = 1; p1_req_write = 0; p1_req_addr = 32'h13;
    #1;
    tests++;
    if (p1_req_ready !== 1'b1 || mem_read !== 1'b0) begin
      failed++; $display("FAIL mis_ready: rdy=%b mr=%b required 1 0", p1_req_ready, mem_read);
    end
    tick();
    p1_req_valid = 0;
    tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== '0 || resp_port !== 1'b1 || mem_read !== 1'b0) begin
      failed++; $display("FAIL mis_resp: rv=%b err=%b data=%h port=%b mr=%b required 1 1 0 1 0",
                         resp_valid, resp_err, resp_data, resp_port, mem_read);
    end
    tick();
    tests++;
    if (resp_valid !== 1'b0 || mem_read !== 1'b0) begin
      failed++; $display("FAIL mis_after: rv=%b mr=%b required 0 0", resp_valid, mem_read);
    end
  endtask

  task automatic test_contention();
    logic exp_port;
    logic [W-1:0] exp_data;
    p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 32'h20;
    p1_req_valid = 1; p1_req_write = 0; p1_req_addr = 32'h28;
    exp_port = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data = exp_port ? 32'h0000_5555 : 32'h0000_4444;
      #1;
      tests++;
      if (p0_req_ready !== ~exp_port || p1_req_ready !== exp_port) begin
        failed++; $display("FAIL rr_grant%0d: rdy p0=%b p1=%b required port %0d", i, p0_req_ready, p1_req_ready, exp_port);
      end
      tick();
      tests++;
      if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
        failed++; $display("FAIL rr_busy%0d: rdy=%b%b required 00", i, p0_req_ready, p1_req_ready);
      end
      tick();
      tests++;
      if (resp_valid !== 1'b1 || resp_port !== exp_port || resp_data !== exp_data) begin
        failed++; $display("FAIL rr_resp%0d: rv=%b port=%b data=%h required 1 %b %h",
                           i, resp_valid, resp_port, resp_data, exp_port, exp_data);
      end
      tick();
      exp_port = ~exp_port;
    end
    p0_req_valid = 0; p1_req_valid = 0;
  endtask

  task automatic test_range();
    p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 32'h2000;
    tick();
    p0_req_valid = 0;
    tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_read !== 1'b0) begin
      failed++; $display("FAIL range_over: rv=%b err=%b mr=%b required 1 1 0", resp_valid, resp_err, mem_read);
    end
    tick();
    p0_req_valid = 1; p0_req_addr = 32'h1FF8;
    tick();
    p0_req_valid = 0;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 32'h1FF8) begin
      failed++; $display("FAIL range_top_issue: mr=%b addr=%h required 1 1ff8", mem_read, mem_address);
    end
    tick();
    tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'hCAFE_F00D) begin
      failed++; $display("FAIL range_top_resp: rv=%b err=%b data=%h required 1 0 cafef00d",
                         resp_valid, resp_err, resp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen_resp;
    p0_req_valid = 1; p0_req_write = 1; p0_req_addr = 32'h30; p0_req_wdata = 32'hBEEF;
    tick();
    p0_req_valid = 0;
    tests++;
    if (mem_write !== 1'b1) begin
      failed++; $display("FAIL mid_issue: mw=%b required 1", mem_write);
    end
    #1 reset_n = 0;
    #1;
    tests++;
    if (mem_write !== 1'b0 || mem_address !== '0 || resp_valid !== 1'b0) begin
      failed++; $display("FAIL mid_drop: mw=%b addr=%h rv=%b required 0 0 0", mem_write, mem_address, resp_valid);
    end
    seen_resp = 0;
    p1_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid !== 1'b0 || p1_req_ready !== 1'b0) seen_resp++;
    end
    p1_req_valid = 0;
    #2 reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid !== 1'b0) seen_resp++;
    end
    tests++;
    if (seen_resp !== 0 || mem[6] !== '0) begin
      failed++; $display("FAIL mid_discard: stray cycles=%0d mem6=%h required 0 0", seen_resp, mem[6]);
    end
    p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 32'h20;
    p1_req_valid = 1; p1_req_write = 0; p1_req_addr = 32'h28;
    #1;
    tests++;
    if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
      failed++; $display("FAIL ptr_restored: rdy p0=%b p1=%b required 1 0", p0_req_ready, p1_req_ready);
    end
    p0_req_valid = 0;
    #1;
    tests++;
    if (p1_req_ready !== 1'b1) begin
      failed++; $display("FAIL p1_alone_ready: rdy=%b required 1", p1_req_ready);
    end
    tick();
    p1_req_valid = 0;
    tick();
    tests++;
    if (resp_valid !== 1'b1 || resp_port !== 1'b1 || resp_data !== 32'h0000_5555) begin
      failed++; $display("FAIL p1_alone_resp: rv=%b port=%b data=%h required 1 1 5555", resp_valid, resp_port, resp_data);
    end
    tick();
  endtask

  task automatic test_nocheck();
    nc_p0_req_valid = 1; nc_p0_req_addr = 32'h13;
    tick();
    nc_p0_req_valid = 0;
    tests++;
    if (nc_mem_read !== 1'b1 || nc_mem_address !== 32'h13) begin
      failed++; $display("FAIL nocheck_issue: mr=%b addr=%h required 1 13", nc_mem_read, nc_mem_address);
    end
    tick();
    tests++;
    if (nc_resp_valid !== 1'b1 || nc_resp_err !== 1'b0 || nc_resp_data !== 32'h1234_5678) begin
      failed++; $display("FAIL nocheck_resp: rv=%b err=%b data=%h required 1 0 12345678",
                         nc_resp_valid, nc_resp_err, nc_resp_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_contention();
    test_range();
    test_reset_mid();
    test_nocheck();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/loader).
- Accepts one transaction at a time over valid/ready handshakes and drives the memory's mem_read, mem_write, address and write_data.
- The memory's read_clk and write_clk are both tied to clk.
- Returns the read data, or a write acknowledge, as a one-cycle response pulse tagged with the originating port.
- Checks alignment and range, so faulting accesses never reach the memory.

Parameters:
- SIZE, 1024, memory depth in `WORD-bit words; must match the memory instance.
- CHECK_EN, 1, 1 = alignment/range checking active; 0 = every request forwarded to memory unchecked.

Ports:
- clk  in  1  system clock; also drives memory read_clk/write_clk.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req_valid  in  1  port 0 request present.
- p0_req_write  in  1  port 0: 1 = store, 0 = load.
- p0_req_addr  in  `WORD  port 0 byte address.
- p0_req_wdata  in  `WORD  port 0 store data.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata, p1_req_ready: same as port 0, for port 1.
- resp_valid  out  1  one-cycle response pulse.
- resp_port  out  1  port the response belongs to.
- resp_data  out  `WORD  load data; 0 for stores and errors.
- resp_err  out  1  access faulted; memory untouched.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_address  out  `WORD  to memory.
- mem_write_data  out  `WORD  to memory.
- mem_read_data  in  `WORD  registered read data from memory.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including both req_ready.
  - mem_read/mem_write drop immediately, even mid-transaction.
  - An in-flight transaction is discarded: no response, no retry.
- States:
  - IDLE:
    - Grant is combinational. Only one valid: grant it. Both valid: grant rr_ptr's port.
    - Winner's req_ready=1 in the same cycle; the loser's req_ready=0.
    - On handshake edge: latch write/addr/wdata/port into cmd registers and set rr_ptr = ~granted port.
    - Next state: ERR if the fault check fails, else ISSUE.
    - Neither valid: stay in IDLE; rr_ptr unchanged.
  - ISSUE (1 cycle):
    - mem_address=cmd_addr, mem_write_data=cmd_wdata.
    - mem_read=~cmd_write, mem_write=cmd_write.
    - Memory samples at the end of this cycle. Next state: RESP.
  - RESP (1 cycle):
    - resp_valid=1, resp_port=cmd_port, resp_err=0.
    - resp_data = mem_read_data for loads, 0 for stores.
    - Next state: IDLE.
  - ERR (1 cycle):
    - resp_valid=1, resp_err=1, resp_data=0, resp_port=cmd_port.
    - mem_read/mem_write stay 0. Next state: IDLE.
- Fault check (CHECK_EN=1): fault if addr[2:0]!=0 (misaligned), or if addr>>3 >= SIZE (compare full width, no truncation).
- Outside ISSUE: mem_read, mem_write, mem_address and mem_write_data are all 0.
- Both req_ready are 0 in every state except IDLE.
- Latency:
  - Handshake edge to resp_valid is 2 cycles for a good access, 1 cycle for a fault.
  - Peak throughput: one good access per 3 cycles.
- No response backpressure: requesters must sink resp_valid unconditionally.
- Request inputs are ignored outside IDLE. Requesters hold valid until ready.
- Fairness: under continuous contention, grants alternate 0,1,0,1...

Decomposition:
- Shared constants package: state encodings (IDLE, ISSUE, RESP, ERR), port IDs, and `WORD reused from the existing constants header.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with registered pointer. Inputs: valid[1:0], advance. Outputs: grant[1:0].

Test Plan:
- Reset, then p0 store addr=0x10, wdata=0xDEAD; then p0 load addr=0x10 -> store: mem_write=1 with mem_address=0x10 in ISSUE, then resp_valid with resp_err=0; load: resp_data=0xDEAD exactly 2 cycles after handshake.
- p0 and p1 both valid continuously with loads -> grants alternate p0,p1,p0,p1; each resp_port matches its request order; one response per 3 cycles.
- p1 load addr=0x13 -> resp_valid with resp_err=1 one cycle after handshake; resp_data=0; mem_read never asserted.
- p0 load addr=SIZE*8 (0x2000) -> resp_err=1; addr=0x1FF8 -> resp_err=0, data read from word 1023.
- Assert reset_n=0 during ISSUE of a store -> mem_write falls immediately, no resp_valid. After release, p1 alone valid -> granted first cycle; rr_ptr=0 restored (check with simultaneous requests).
- CHECK_EN=0, load addr=0x13 -> forwarded to memory, resp_err=0.
